// File: rtl/rgb2ycbcr_pipe_if.sv
// rtl/rgb2ycbcr_pipe_if.sv - Stream bundle for rgb2ycbcr_pipe: RGB pixels in, YCbCr pixels out, frame stats.
interface rgb2ycbcr_pipe_if #(
  parameter int PIX_CNT_W = 22
);
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_r;
  logic [7:0]           in_g;
  logic [7:0]           in_b;
  logic                 in_sof;
  logic                 in_eof;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_y;
  logic [7:0]           out_cb;
  logic [7:0]           out_cr;
  logic                 out_sof;
  logic                 out_eof;
  logic [PIX_CNT_W-1:0] frame_pixels;
  logic                 frame_done;

  modport master (
    output in_valid, in_r, in_g, in_b, in_sof, in_eof, out_ready,
    input  in_ready, out_valid, out_y, out_cb, out_cr, out_sof, out_eof,
           frame_pixels, frame_done
  );

  modport slave (
    input  in_valid, in_r, in_g, in_b, in_sof, in_eof, out_ready,
    output in_ready, out_valid, out_y, out_cb, out_cr, out_sof, out_eof,
           frame_pixels, frame_done
  );
endinterface

// File: rtl/rgb2ycbcr_pipe.sv
// rtl/rgb2ycbcr_pipe.sv - 3-stage RGB888 to full-range BT.601 YCbCr 4:4:4 converter with backpressure.
// Macro RGB2YCBCR_FRAME_STATS_EN enables the per-frame pixel counter (frame_pixels/frame_done).
module rgb2ycbcr_pipe #(
  parameter int PIX_CNT_W = 22
) (
  input  logic            clk,
  input  logic            rst,
  rgb2ycbcr_pipe_if.slave bus
);
  typedef logic signed [16:0] prod_t;
  typedef logic signed [18:0] sum_t;

  localparam logic signed [8:0] K_Y_R  = 9'sd77;
  localparam logic signed [8:0] K_Y_G  = 9'sd150;
  localparam logic signed [8:0] K_Y_B  = 9'sd29;
  localparam logic signed [8:0] K_CB_R = -9'sd43;
  localparam logic signed [8:0] K_CB_G = -9'sd85;
  localparam logic signed [8:0] K_CB_B = 9'sd128;
  localparam logic signed [8:0] K_CR_R = 9'sd128;
  localparam logic signed [8:0] K_CR_G = -9'sd107;
  localparam logic signed [8:0] K_CR_B = -9'sd21;
  localparam sum_t Y_ROUND = 19'sd128;
  localparam sum_t C_ROUND = 19'sd32896;

  function automatic prod_t mul(input logic [7:0] px, input logic signed [8:0] k);
    prod_t a;
    prod_t b;
    a = $signed({9'd0, px});
    b = prod_t'(k);
    return a * b;
  endfunction

  function automatic sum_t add3(input prod_t a, input prod_t b, input prod_t c, input sum_t rnd);
    return sum_t'(a) + sum_t'(b) + sum_t'(c) + rnd;
  endfunction

  // Negative branch cannot trigger with these coefficients; kept so the stage is safe to retune.
  function automatic logic [7:0] clamp8(input sum_t s);
    sum_t q;
    q = s >>> 8;
    if (q < 19'sd0)
      return 8'd0;
    else if (q > 19'sd255)
      return 8'hFF;
    else
      return q[7:0];
  endfunction

  logic  advance;
  logic  v1, sof1, eof1;
  logic  v2, sof2, eof2;
  logic  v3, sof3, eof3;
  prod_t p_yr, p_yg, p_yb, p_cbr, p_cbg, p_cbb, p_crr, p_crg, p_crb;
  sum_t  s_y, s_cb, s_cr;
  logic [7:0] y3, cb3, cr3;

  // Whole pipe moves as one; bubbles travel with it rather than being squeezed out.
  assign advance      = !v3 || bus.out_ready;
  assign bus.in_ready = advance || rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      sof1 <= 1'b0;
      eof1 <= 1'b0;
      v2   <= 1'b0;
      sof2 <= 1'b0;
      eof2 <= 1'b0;
      v3   <= 1'b0;
      sof3 <= 1'b0;
      eof3 <= 1'b0;
    end else if (advance) begin
      v1   <= bus.in_valid;
      sof1 <= bus.in_valid && bus.in_sof;
      eof1 <= bus.in_valid && bus.in_eof;
      v2   <= v1;
      sof2 <= sof1;
      eof2 <= eof1;
      v3   <= v2;
      sof3 <= sof2;
      eof3 <= eof2;
    end
  end

  always_ff @(posedge clk) begin
    if (advance && bus.in_valid) begin
      p_yr  <= mul(bus.in_r, K_Y_R);
      p_yg  <= mul(bus.in_g, K_Y_G);
      p_yb  <= mul(bus.in_b, K_Y_B);
      p_cbr <= mul(bus.in_r, K_CB_R);
      p_cbg <= mul(bus.in_g, K_CB_G);
      p_cbb <= mul(bus.in_b, K_CB_B);
      p_crr <= mul(bus.in_r, K_CR_R);
      p_crg <= mul(bus.in_g, K_CR_G);
      p_crb <= mul(bus.in_b, K_CR_B);
    end
  end

  always_ff @(posedge clk) begin
    if (advance && v1) begin
      s_y  <= add3(p_yr, p_yg, p_yb, Y_ROUND);
      s_cb <= add3(p_cbr, p_cbg, p_cbb, C_ROUND);
      s_cr <= add3(p_crr, p_crg, p_crb, C_ROUND);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y3  <= 8'd0;
      cb3 <= 8'd0;
      cr3 <= 8'd0;
    end else if (advance && v2) begin
      y3  <= clamp8(s_y);
      cb3 <= clamp8(s_cb);
      cr3 <= clamp8(s_cr);
    end
  end

  assign bus.out_valid = v3;
  assign bus.out_sof   = sof3;
  assign bus.out_eof   = eof3;
  assign bus.out_y     = y3;
  assign bus.out_cb    = cb3;
  assign bus.out_cr    = cr3;

`ifdef RGB2YCBCR_FRAME_STATS_EN
  logic [PIX_CNT_W-1:0] pix_cnt;
  logic [PIX_CNT_W-1:0] cnt_next;
  logic [PIX_CNT_W-1:0] frame_pixels_q;
  logic                 frame_done_q;
  logic                 handshake;

  assign handshake = v3 && bus.out_ready;

  always_comb begin
    cnt_next = pix_cnt;
    if (sof3)
      cnt_next = PIX_CNT_W'(1);
    else if (!(&pix_cnt))
      cnt_next = pix_cnt + PIX_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt        <= '0;
      frame_pixels_q <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      frame_done_q <= handshake && eof3;
      if (handshake) begin
        pix_cnt <= cnt_next;
        if (eof3)
          frame_pixels_q <= cnt_next;
      end
    end
  end

  assign bus.frame_pixels = frame_pixels_q;
  assign bus.frame_done   = frame_done_q;
`else
  assign bus.frame_pixels = {PIX_CNT_W{1'b0}};
  assign bus.frame_done   = 1'b0;
`endif
endmodule

// File: tb/tb_rgb2ycbcr_pipe.sv
// tb/tb_rgb2ycbcr_pipe.sv - Randomized scoreboard bench for rgb2ycbcr_pipe against an integer BT.601 model.
module tb_rgb2ycbcr_pipe;
  localparam int PIX_CNT_W = 22;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    logic       sof;
    logic       eof;
  } pix_t;

  logic clk;
  logic rst;
  logic rand_ready;
  int   n_vec;
  int   n_err;
  int   done_cnt;
  logic hold_valid;
  pix_t hold_px;
  pix_t exp_q[$];

  rgb2ycbcr_pipe_if #(.PIX_CNT_W(PIX_CNT_W)) bus ();

  rgb2ycbcr_pipe #(.PIX_CNT_W(PIX_CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] sat(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  function automatic pix_t ref_pix(input int r, input int g, input int b, input logic sof, input logic eof);
    pix_t e;
    e.y   = sat((77 * r + 150 * g + 29 * b + 128) / 256);
    e.cb  = sat((-43 * r - 85 * g + 128 * b + 32896) / 256);
    e.cr  = sat((128 * r - 107 * g - 21 * b + 32896) / 256);
    e.sof = sof;
    e.eof = eof;
    return e;
  endfunction

  always @(negedge clk) begin
    pix_t e;
    check("in_ready", 32'(bus.in_ready), 32'(rst || !bus.out_valid || bus.out_ready));
    if (rst) begin
      exp_q.delete();
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", 32'({bus.out_y, bus.out_cb, bus.out_cr, bus.out_sof, bus.out_eof}), 32'(hold_px));
      end
      if (bus.out_valid && bus.out_ready) begin
        check("out_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("y", 32'(bus.out_y), 32'(e.y));
          check("cb", 32'(bus.out_cb), 32'(e.cb));
          check("cr", 32'(bus.out_cr), 32'(e.cr));
          check("sof", 32'(bus.out_sof), 32'(e.sof));
          check("eof", 32'(bus.out_eof), 32'(e.eof));
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(ref_pix(int'(bus.in_r), int'(bus.in_g), int'(bus.in_b), bus.in_sof, bus.in_eof));
      hold_valid = bus.out_valid && !bus.out_ready;
      hold_px    = '{bus.out_y, bus.out_cb, bus.out_cr, bus.out_sof, bus.out_eof};
      if (bus.frame_done) done_cnt++;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      bus.out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic sof, input logic eof);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_r = r;
    bus.in_g = g;
    bus.in_b = b;
    bus.in_sof = sof;
    bus.in_eof = eof;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_sof = 1'($urandom);
    bus.in_eof = 1'($urandom);
    bus.in_r = 8'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_out(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", 32'(ok), 32'd1);
  endtask

  int pat [4][6] = '{
    '{255, 255, 255, 255, 128, 128},
    '{255,   0,   0,  77,  85, 255},
    '{  0,   0, 255,  29, 255, 107},
    '{  0, 255,   0, 149,  43,  21}
  };

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic ok;
    n_vec = 0;
    n_err = 0;
    done_cnt = 0;
    hold_valid = 1'b0;
    rand_ready = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_r = 8'd0;
    bus.in_g = 8'd0;
    bus.in_b = 8'd0;
    bus.in_sof = 1'b0;
    bus.in_eof = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'({bus.out_y, bus.out_cb, bus.out_cr}), 32'd0);
    check("rst_sideband", 32'({bus.out_sof, bus.out_eof}), 32'd0);
    check("rst_frame_pixels", 32'(bus.frame_pixels), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    @(posedge clk);
    #1;

    send(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    idle(0);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    check("latency", 32'(lat), 32'd3);
    check("black_y", 32'(bus.out_y), 32'd0);
    check("black_cb", 32'(bus.out_cb), 32'd128);
    check("black_cr", 32'(bus.out_cr), 32'd128);
    @(posedge clk);
    #1;

    fork
      begin
        for (int j = 0; j < 4; j++)
          send(8'(pat[j][0]), 8'(pat[j][1]), 8'(pat[j][2]), 1'b0, 1'b0);
        idle(0);
      end
      begin
        for (int j = 0; j < 4; j++) begin
          wait_out(ok);
          check("pat_seen", 32'(ok), 32'd1);
          check("pat_y", 32'(bus.out_y), 32'(pat[j][3]));
          check("pat_cb", 32'(bus.out_cb), 32'(pat[j][4]));
          check("pat_cr", 32'(bus.out_cr), 32'(pat[j][5]));
        end
      end
    join
    @(posedge clk);
    #1;
    drain();

    fork
      begin
        for (int i = 0; i < 16; i++)
          send(8'(i * 16), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        idle(0);
      end
      begin
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    done_cnt = 0;
    for (int i = 0; i < 10; i++)
      send(8'($urandom), 8'($urandom), 8'($urandom), i == 0, i == 9);
    idle(0);
    drain();
    idle(3);
`ifdef RGB2YCBCR_FRAME_STATS_EN
    check("frame_done_count", 32'(done_cnt), 32'd1);
    check("frame_pixels", 32'(bus.frame_pixels), 32'd10);
`else
    check("frame_done_count", 32'(done_cnt), 32'd0);
    check("frame_pixels", 32'(bus.frame_pixels), 32'd0);
`endif

    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0)
        send(8'($urandom), 8'($urandom), 8'($urandom),
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      else
        idle(1);
    end
    idle(0);
    rand_ready = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain();

    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b1);
    idle(0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_data", 32'({bus.out_y, bus.out_cb, bus.out_cr}), 32'd0);
    check("post_rst_sideband", 32'({bus.out_sof, bus.out_eof}), 32'd0);
    @(posedge clk);
    #1;
    idle(10);
    check("post_rst_queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
